// File: rtl/instruction_fetcher_pkg.sv
// rtl/instruction_fetcher_pkg.sv - shared widths, JAL opcode and fetch FSM encodings
package instruction_fetcher_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;
  localparam int ADDR_MSB   = ADDR_W_DEF - 1;
  localparam int INST_MSB   = INST_W_DEF - 1;

  typedef logic [ADDR_MSB:0] addr_t;
  typedef logic [INST_MSB:0] inst_t;

  localparam int         PC_STEP    = 4;
  localparam logic [6:0] JAL_OPCODE = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetcher_jal_imm_decode.sv
// rtl/instruction_fetcher_jal_imm_decode.sv - combinational JAL detect and J-immediate extraction
module jal_imm_decode
  import instruction_fetcher_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic [INST_W-1:0] inst,
  output logic              is_jal,
  output logic [ADDR_W-1:0] imm
);

  logic unused_rd;

  assign is_jal    = (inst[6:0] == JAL_OPCODE);
  // imm[20|10:1|11|19:12] lives scrambled in inst[31:12]; bit 0 is always zero
  assign imm       = {{(ADDR_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign unused_rd = ^inst[11:7];

endmodule

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - single-outstanding fetch FSM; FETCH_JAL_PREDICT_EN enables JAL target prediction
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int ADDR_W            = 32,
  parameter int INST_W            = 32,
  parameter bit CTRL_SHARED_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              if_write_sig_out,
  output logic [ADDR_W-1:0] if_write_pc_out,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [INST_W-1:0] mem_resp_data,
  input  logic              queue_full,
  output logic              inst_valid_out,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc_out,
  input  logic              flush_in,
  input  logic [ADDR_W-1:0] flush_pc_in
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] req_addr;
  logic [INST_W-1:0] held_word;
  logic              stale;
  logic [INST_W-1:0] emit_word;
  logic [ADDR_W-1:0] emit_next_pc;

  assign emit_word = (state == ST_HOLD) ? held_word : mem_resp_data;

`ifdef FETCH_JAL_PREDICT_EN
  logic              is_jal;
  logic [ADDR_W-1:0] jal_imm;

  jal_imm_decode #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_jal_imm_decode (
    .inst   (emit_word),
    .is_jal (is_jal),
    .imm    (jal_imm)
  );

  assign emit_next_pc = is_jal ? (req_addr + jal_imm) : (req_addr + ADDR_W'(PC_STEP));
`else
  assign emit_next_pc = req_addr + ADDR_W'(PC_STEP);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      req_addr         <= '0;
      held_word        <= '0;
      mem_req_valid    <= 1'b0;
      mem_req_addr     <= '0;
      inst_valid_out   <= 1'b0;
      inst_out         <= '0;
      inst_pc_out      <= '0;
      if_write_sig_out <= 1'b0;
      if_write_pc_out  <= '0;
      // A controller that survives our reset still owes a response for an in-flight request
      stale            <= CTRL_SHARED_RESET ? 1'b0
                          : (stale || state == ST_WAIT || state == ST_DRAIN);
    end else if (rdy) begin
      mem_req_valid    <= 1'b0;
      inst_valid_out   <= 1'b0;
      if_write_sig_out <= 1'b0;
      if (mem_resp_valid) begin
        stale <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (flush_in) begin
            if_write_sig_out <= 1'b1;
            if_write_pc_out  <= flush_pc_in;
          end else if (!queue_full && !if_write_sig_out && !stale) begin
            // The bubble after a PC write keeps pc_in from being sampled stale
            mem_req_valid <= 1'b1;
            mem_req_addr  <= pc_in;
            req_addr      <= pc_in;
            state         <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (flush_in) begin
            if_write_sig_out <= 1'b1;
            if_write_pc_out  <= flush_pc_in;
            state            <= mem_resp_valid ? ST_IDLE : ST_DRAIN;
          end else if (mem_resp_valid) begin
            if (!queue_full) begin
              inst_valid_out   <= 1'b1;
              inst_out         <= emit_word;
              inst_pc_out      <= req_addr;
              if_write_sig_out <= 1'b1;
              if_write_pc_out  <= emit_next_pc;
              state            <= ST_IDLE;
            end else begin
              held_word <= mem_resp_data;
              state     <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (flush_in) begin
            held_word        <= '0;
            if_write_sig_out <= 1'b1;
            if_write_pc_out  <= flush_pc_in;
            state            <= ST_IDLE;
          end else if (!queue_full) begin
            inst_valid_out   <= 1'b1;
            inst_out         <= emit_word;
            inst_pc_out      <= req_addr;
            if_write_sig_out <= 1'b1;
            if_write_pc_out  <= emit_next_pc;
            state            <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (flush_in) begin
            if_write_sig_out <= 1'b1;
            if_write_pc_out  <= flush_pc_in;
          end
          if (mem_resp_valid) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 Parameters: ADDR_W, 32, PC/address width; INST_W, 32, instruction width.
REQ-002 clk  in  1  the single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 rdy  in  1  global ready; when low, every register (including outputs) SHALL hold its value.
REQ-005 pc_in  in  ADDR_W  current PC from the PC register.
REQ-006 if_write_sig_out  out  1  one-cycle pulse requesting a PC-register update.
REQ-007 if_write_pc_out  out  ADDR_W  new PC; valid only while if_write_sig_out is high.
REQ-008 mem_req_valid  out  1  one-cycle fetch request pulse to the memory controller.
REQ-009 mem_req_addr  out  ADDR_W  fetch address, valid with mem_req_valid.
REQ-010 mem_resp_valid  in  1  one-cycle response pulse; exactly one per request, arriving at least 1 cycle after the request.
REQ-011 mem_resp_data  in  INST_W  fetched word, valid with mem_resp_valid.
REQ-012 queue_full  in  1  downstream instruction queue cannot accept an entry this cycle.
REQ-013 inst_valid_out  out  1  one-cycle pulse delivering an instruction.
REQ-014 inst_out / inst_pc_out  out  INST_W / ADDR_W  instruction and its PC, valid with inst_valid_out.
REQ-015 flush_in / flush_pc_in  in  1 / ADDR_W  misprediction redirect and its target PC.

Function
REQ-016 FSM states: IDLE, WAIT, HOLD, DRAIN; all outputs SHALL be registered.
REQ-017 IDLE: request SHALL be issued when rdy, !flush_in, !queue_full, and if_write_sig_out was low in the previous cycle. Issue means mem_req_valid=1 and mem_req_addr=pc_in for one cycle, then go to WAIT.
REQ-018 The one-cycle bubble after any PC write is mandatory, so pc_in is never stale.
REQ-019 WAIT with mem_resp_valid and !queue_full: next cycle inst_valid_out=1, inst_out=mem_resp_data, inst_pc_out=request address, if_write_sig_out=1, if_write_pc_out=request address+4; then go to IDLE.
REQ-020 WAIT with mem_resp_valid and queue_full: latch the word and go to HOLD; HOLD emits as in REQ-019 in the first cycle queue_full is low.
REQ-021 PC arithmetic SHALL be modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-022 flush_in in IDLE or HOLD: discard any held word, pulse if_write_sig_out with if_write_pc_out=flush_pc_in, then go to IDLE.
REQ-023 flush_in in WAIT: same PC write, but go to DRAIN; DRAIN discards the pending response and goes to IDLE when it arrives.
REQ-024 Response and flush in the same cycle: flush wins and the response is discarded (next state IDLE, nothing emitted).
REQ-025 Flush during DRAIN: latest flush_pc_in is written; remain in DRAIN.
REQ-026 At most one request is outstanding at any time; inst_valid_out is never asserted while queue_full is high.

Reset
REQ-027 rst SHALL force state=IDLE and zero all outputs: mem_req_valid, inst_valid_out, if_write_sig_out, addresses and data.
REQ-028 Reset mid-WAIT: a response arriving after reset SHALL be ignored. A one-bit stale flag, cleared on a response or after the memory controller's reset, is set by reset only when the controller does not reset simultaneously; it is defaulted to assume a simultaneous reset, i.e. cleared.

Configuration
REQ-029 Macro FETCH_JAL_PREDICT_EN.
- Defined: an emitted instruction with opcode 7'b1101111 (JAL) writes if_write_pc_out = PC + sign-extended J-immediate instead of PC+4.
- Undefined: always PC+4; the decode logic is absent.

Structure
REQ-030 The shared defines file SHALL hold AddrType/InstType width ranges, the JAL opcode constant, and the FSM state encodings.
REQ-031 One sub-module, jal_imm_decode (combinational J-immediate extraction), SHALL be instantiated only under FETCH_JAL_PREDICT_EN.

Verification
REQ-032 pc_in=0x100, response 0x00000013 after 3 cycles -> inst_valid_out with inst=0x13, pc=0x100; PC write 0x104; next request is not before 2 cycles later.
REQ-033 queue_full=1 on response 0xDEADBEEF, released 5 cycles later -> exactly one emission, 1 cycle after release; no request while held.
REQ-034 flush_in (pc 0x200) while in WAIT -> PC write 0x200; the late response is not emitted; next request addr=0x200.
REQ-035 Flush and response in the same cycle -> no inst_valid_out; PC write = flush_pc_in.
REQ-036 pc=0xFFFFFFFC -> PC write 0x00000000; with FETCH_JAL_PREDICT_EN, JAL word 0x0080006F at 0x100 -> PC write 0x108.
REQ-037 rdy dropped for 4 cycles mid-WAIT with the response held by the controller -> all outputs frozen; behaviour resumes identically.
